// File: rtl/transfer_pkg.sv
// rtl/transfer_pkg.sv - shared state type and counter-width helpers for the transfer direction scheduler
package transfer_pkg;

    // Per-channel direction FSM states.
    typedef enum logic [2:0] {
        ST_RX       = 3'd0,
        ST_RX_DRAIN = 3'd1,
        ST_TURN_TX  = 3'd2,
        ST_TX       = 3'd3,
        ST_TX_DRAIN = 3'd4,
        ST_TURN_RX  = 3'd5
    } dir_state_t;

    // Bits needed to hold 0..max_val inclusive (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int burst_cnt_width(input int max_burst);
        return cnt_width(max_burst);
    endfunction

    function automatic int win_cnt_width(input int rx_win);
        return cnt_width(rx_win);
    endfunction

    function automatic int turn_cnt_width(input int turn_cyc);
        return cnt_width(turn_cyc);
    endfunction

endpackage

// File: rtl/transfer_dir_chan.sv
// rtl/transfer_dir_chan.sv - one channel of the link direction scheduler (FSM plus counters)
//
// Ports:
//   clk, rst     clock and synchronous active-low reset
//   tx_pending   local send path holds data
//   rq           treated remote request pin (receive direction)
//   ak           treated remote acknowledge pin (send direction)
//   req_send     request currently driven by the local send path
//   ack_recv     acknowledge currently driven by the local receive path
//   oen          registered link direction, 1 = send
//   tx_grant     registered permission for new send handshakes
//   rx_grant     registered permission to acknowledge new requests
module transfer_dir_chan
    import transfer_pkg::*;
#(
    parameter int TURN_CYC  = 4,
    parameter int MAX_BURST = 16,
    parameter int RX_WIN    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_pending,
    input  logic rq,
    input  logic ak,
    input  logic req_send,
    input  logic ack_recv,
    output logic oen,
    output logic tx_grant,
    output logic rx_grant
);

    localparam int BW = burst_cnt_width(MAX_BURST);
    localparam int WW = win_cnt_width(RX_WIN);
    localparam int TW = turn_cnt_width(TURN_CYC);

    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [WW-1:0] WIN_MAX   = WW'(RX_WIN);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

    dir_state_t    state;
    dir_state_t    state_next;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] win_cnt;
    logic [TW-1:0] turn_cnt;
    logic          ak_q;
    logic          ak_fall;
    logic          in_turn;

    // A completed send handshake is marked by the remote acknowledge falling.
    assign ak_fall = ak_q & ~ak;
    assign in_turn = (state == ST_TURN_TX) || (state == ST_TURN_RX);

    always_comb begin
        state_next = state;
        case (state)
            ST_RX: begin
                if ((win_cnt == WIN_MAX) && tx_pending && !rq && !ack_recv) begin
                    state_next = ST_RX_DRAIN;
                end
            end
            ST_RX_DRAIN: begin
                // A request arriving during the drain cycle wins over the turnaround.
                state_next = rq ? ST_RX : ST_TURN_TX;
            end
            ST_TURN_TX: begin
                if (turn_cnt == TURN_LAST) begin
                    state_next = ST_TX;
                end
            end
            ST_TX: begin
                if ((burst_cnt == BURST_MAX) || !tx_pending) begin
                    state_next = ST_TX_DRAIN;
                end
            end
            ST_TX_DRAIN: begin
                // Never turn around with a send handshake still open.
                if (!req_send && !ak) begin
                    state_next = ST_TURN_RX;
                end
            end
            ST_TURN_RX: begin
                if (turn_cnt == TURN_LAST) begin
                    state_next = ST_RX;
                end
            end
            default: begin
                state_next = ST_RX;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RX;
            burst_cnt <= '0;
            win_cnt   <= '0;
            turn_cnt  <= '0;
            ak_q      <= 1'b0;
            oen       <= 1'b0;
            tx_grant  <= 1'b0;
            rx_grant  <= 1'b0;
        end else begin
            state <= state_next;
            ak_q  <= ak;

            // Outputs are decoded from the next state so they land with the state change.
            oen      <= (state_next == ST_TURN_TX) || (state_next == ST_TX) ||
                        (state_next == ST_TX_DRAIN);
            tx_grant <= (state_next == ST_TX);
            rx_grant <= (state_next == ST_RX);

            // RX window: cleared on a fresh RX tenure, kept when the drain is aborted.
            if ((state == ST_TURN_RX) && (state_next == ST_RX)) begin
                win_cnt <= '0;
            end else if ((state == ST_RX) && (win_cnt != WIN_MAX)) begin
                win_cnt <= win_cnt + WW'(1);
            end

            // Burst count covers TX and the drain, so a final handshake is still counted.
            if ((state == ST_TURN_TX) && (state_next == ST_TX)) begin
                burst_cnt <= '0;
            end else if (((state == ST_TX) || (state == ST_TX_DRAIN)) && ak_fall &&
                         (burst_cnt != BURST_MAX)) begin
                burst_cnt <= burst_cnt + BW'(1);
            end

            // Turnaround counter restarts on every state change.
            if (state_next != state) begin
                turn_cnt <= '0;
            end else if (in_turn && (turn_cnt != TURN_LAST)) begin
                turn_cnt <= turn_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/transfer_dir_sched.sv
// rtl/transfer_dir_sched.sv - per-channel direction scheduler for the bidirectional transfer link
//
// Ports:
//   clk, rst     clock and synchronous active-low reset
//   tx_pending   per channel: local send path holds data
//   REQ_RECV     per channel: request pin while receiving (asynchronous)
//   ACK_SEND     per channel: acknowledge pin while sending (asynchronous)
//   REQ_SEND     per channel: request driven by the local send path
//   ACK_RECV     per channel: acknowledge driven by the local receive path
//   oen          per channel: link direction, 1 = send
//   tx_grant     per channel: send path may start new handshakes
//   rx_grant     per channel: receive path may acknowledge new requests
//
// Build option TRANSFER_DIR_SYNC_EN: when defined, REQ_RECV and ACK_SEND pass
// through 2-flop synchronizers; otherwise they are used directly.
module transfer_dir_sched
    import transfer_pkg::*;
#(
    parameter int All_Channel = 4,
    parameter int TURN_CYC    = 4,
    parameter int MAX_BURST   = 16,
    parameter int RX_WIN      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [All_Channel-1:0] tx_pending,
    input  logic [All_Channel-1:0] REQ_RECV,
    input  logic [All_Channel-1:0] ACK_SEND,
    input  logic [All_Channel-1:0] REQ_SEND,
    input  logic [All_Channel-1:0] ACK_RECV,
    output logic [All_Channel-1:0] oen,
    output logic [All_Channel-1:0] tx_grant,
    output logic [All_Channel-1:0] rx_grant
);

    logic [All_Channel-1:0] rq;
    logic [All_Channel-1:0] ak;

`ifdef TRANSFER_DIR_SYNC_EN
    logic [All_Channel-1:0] rq_s1;
    logic [All_Channel-1:0] rq_s2;
    logic [All_Channel-1:0] ak_s1;
    logic [All_Channel-1:0] ak_s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rq_s1 <= '0;
            rq_s2 <= '0;
            ak_s1 <= '0;
            ak_s2 <= '0;
        end else begin
            rq_s1 <= REQ_RECV;
            rq_s2 <= rq_s1;
            ak_s1 <= ACK_SEND;
            ak_s2 <= ak_s1;
        end
    end

    assign rq = rq_s2;
    assign ak = ak_s2;
`else
    // Same-clock loopback: pins are already synchronous to clk.
    assign rq = REQ_RECV;
    assign ak = ACK_SEND;
`endif

    for (genvar g = 0; g < All_Channel; g++) begin : g_chan
        transfer_dir_chan #(
            .TURN_CYC  (TURN_CYC),
            .MAX_BURST (MAX_BURST),
            .RX_WIN    (RX_WIN)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tx_pending (tx_pending[g]),
            .rq         (rq[g]),
            .ak         (ak[g]),
            .req_send   (REQ_SEND[g]),
            .ack_recv   (ACK_RECV[g]),
            .oen        (oen[g]),
            .tx_grant   (tx_grant[g]),
            .rx_grant   (rx_grant[g])
        );
    end

endmodule

// File: doc/transfer_dir_sched.md
# transfer_dir_sched

Per-channel direction scheduler for the bidirectional PAICORE transfer link. It drives the `oen` bus of the transfer IO buffer block: `oen=0` means receive (request/data pins in, acknowledge out) and `oen=1` means send (request/data pins out, acknowledge in). For each channel it time-shares the link between local send traffic and remote receive traffic. It only turns the link around when the 4-phase handshake is idle, and it inserts dead cycles on every turnaround.

## Interface
- `All_Channel`, 4, number of independent channels.
- `TURN_CYC`, 4, dead cycles after an `oen` change before any grant is issued (≥1).
- `MAX_BURST`, 16, maximum completed send transactions per TX tenure (≥1).
- `RX_WIN`, 32, minimum cycles spent granted in RX before TX may be entered (≥1).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-low: reset is applied when `rst=0` at a rising `clk`.
- `tx_pending`  in  All_Channel  local send path holds data for the channel.
- `REQ_RECV`  in  All_Channel  request pin value while receiving (asynchronous).
- `ACK_SEND`  in  All_Channel  acknowledge pin value while sending (asynchronous).
- `REQ_SEND`  in  All_Channel  request currently driven by the local send path.
- `ACK_RECV`  in  All_Channel  acknowledge currently driven by the local receive path.
- `oen`  out  All_Channel  link direction; 1 means send.
- `tx_grant`  out  All_Channel  send path may start new handshakes.
- `rx_grant`  out  All_Channel  receive path may acknowledge new requests.

## Operation
- Channels are fully independent. Each channel has its own FSM, turnaround counter, burst counter and window counter.
- `REQ_RECV` and `ACK_SEND` are used only after the input-path treatment described under Configuration. In the rules below, `rq` and `ak` denote those treated values.
- FSM states and transitions:
  - **RX**: `oen=0`, `rx_grant=1`. The window counter increments while below `RX_WIN`. Go to **RX_DRAIN** when window=`RX_WIN`, `tx_pending=1`, `rq=0` and `ACK_RECV=0`.
  - **RX_DRAIN**: `rx_grant=0`, one cycle. If `rq=1` in this cycle, return to **RX** and keep the window at `RX_WIN`. Otherwise set `oen=1` and go to **TURN_TX**.
  - **TURN_TX**: `oen=1`, no grants, lasts `TURN_CYC` cycles. Then go to **TX** and clear the burst counter.
  - **TX**: `tx_grant=1`. Each falling edge of `ak` increments the burst counter. Go to **TX_DRAIN** when the count reaches `MAX_BURST` or `tx_pending=0`.
  - **TX_DRAIN**: `tx_grant=0`. Wait until `REQ_SEND=0` and `ak=0`, and count any final falling edge. Then set `oen=0` and go to **TURN_RX**.
  - **TURN_RX**: `oen=0`, no grants, lasts `TURN_CYC` cycles. Then go to **RX** with the window cleared.
- A TX tenure never ends mid-handshake. This holds even if `tx_pending` drops while `REQ_SEND=1`.
- If `tx_pending` is asserted with no burst activity, the result is a TX tenure with 0 transfers. This is legal.
- Counters saturate and never wrap. The burst counter is `$clog2(MAX_BURST+1)` bits wide; the window counter is `$clog2(RX_WIN+1)` bits wide.

## Timing
- All outputs are registered.
- Reset values: `oen=0`, `tx_grant=0`, `rx_grant=0`; FSM in RX with all counters at 0. `rx_grant` rises on the first edge after `rst` returns high.
- Reset mid-operation takes effect at the next edge regardless of state, including TX with a handshake in flight. The datapath is reset by the same `rst`.
- `oen` never changes in a cycle where either grant is 1. Every `oen` edge is followed by at least `TURN_CYC` grant-free cycles.
- Latency is measured from the RX exit condition being true at edge k, ignoring input-path delay:
  - edge k+1: `rx_grant` falls.
  - edge k+2: `oen` rises.
  - edge k+2+`TURN_CYC`: `tx_grant` rises.
- Simultaneous `rq` rise and the RX_DRAIN decision: the remote side wins and the channel stays in RX.

## Configuration
- `TRANSFER_DIR_SYNC_EN` defined: `REQ_RECV` and `ACK_SEND` each pass through a 2-flop synchronizer per bit. All pin-derived decisions gain 2 cycles of latency.
- `TRANSFER_DIR_SYNC_EN` undefined: the inputs are used directly through a single edge-detect register. This build is for simulation and same-clock board loopback.

## Structure
- The shared package `transfer_pkg` holds:
  - the state enum: RX, RX_DRAIN, TURN_TX, TX, TX_DRAIN, TURN_RX;
  - the counter-width helper functions.
- Sub-module `transfer_dir_chan` implements one channel's FSM and counters. The top level instantiates it `All_Channel` times with a generate loop and holds the optional synchronizers.

## Test plan
- Reset, `tx_pending=0`, 100 cycles: `oen=0`, `rx_grant=1` from cycle 1, `tx_grant` always 0.
- `TURN_CYC=4`, `RX_WIN=32`; set `tx_pending=1` at cycle 0: `rx_grant` falls at cycle 33, `oen` rises at 34, `tx_grant` rises at 38.
- `MAX_BURST=16`, `tx_pending` held at 1: after 16 `ak` falls `tx_grant` falls, `oen` returns to 0, and the next `tx_grant` comes no earlier than 32 RX cycles later.
- Drop `tx_pending` while `REQ_SEND=1`: `oen` stays 1 until `REQ_SEND=0` and `ak=0`, then 4 idle cycles, then `rx_grant=1`.
- Raise `rq` in the RX_DRAIN cycle: `oen` stays 0, `rx_grant` returns to 1 the next cycle, and TX is entered only after `rq` and `ACK_RECV` are both low.
- Pull `rst` low during TX on channel 2 while channels 0, 1 and 3 are in other states: all channels show `oen=0` and both grants 0 at the next edge.
